ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_sync_edge.sv | 32 +++
 rtl/ps2_host_tx.sv | 171 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// frame constants and default timing.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_XFER,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    // One frame is 11 device clocks: start, 8 data, parity, stop; ACK on the 11th fall.
    localparam int FRAME_CLOCKS = 11;
    localparam int DATA_BITS    = 8;
    localparam int STOP_EDGE    = FRAME_CLOCKS - 1;

    // 100 us inhibit and 2 ms watchdog at 50 MHz.
    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_TIMEOUT_CYCLES = 100000;

    // PS/2 uses odd parity: the parity bit makes the count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one asynchronous PS/2 line plus a detector for
// 1->0 transitions of the synchronized value. Lines idle high, so the flops
// reset to 1 to avoid a false edge after reset.
module ps2_sync_edge (
    input  logic clk,
    input  logic areset_n,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resynchronize the line and keep one cycle of history for edge detection.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: inhibits the bus, issues request-to-send, shifts a
// command byte out on device clock falling edges and checks the device ACK.
// Optional watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk_50,
    input  logic       areset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 2;

    state_t             state;
    logic [7:0]         data_q;
    logic               parity_q;
    logic [INH_W-1:0]   inh_cnt;
    logic [3:0]         edge_cnt;
    logic               ack_bad;

    logic               clk_s;
    logic               clk_fall;
    logic               dat_s;
    logic               dat_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk      (clk_50),
        .areset_n (areset_n),
        .async_in (ps2_clk),
        .sync_out (clk_s),
        .fall     (clk_fall)
    );

    // The transmitter only samples the data level; its edges are not needed.
    ps2_sync_edge u_dat_sync (
        .clk      (clk_50),
        .areset_n (areset_n),
        .async_in (ps2_dat),
        .sync_out (dat_s),
        .fall     (dat_fall_unused)
    );

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
    logic [WD_W-1:0] wd_cnt;
    logic            timeout_q;
`endif

    // Transfer sequencer; every output that touches the bus is a register.
    always_ff @(posedge clk_50 or negedge areset_n) begin
        if (!areset_n) begin
            state      <= ST_IDLE;
            data_q     <= '0;
            parity_q   <= 1'b0;
            inh_cnt    <= '0;
            edge_cnt   <= '0;
            ack_bad    <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b0;
            ack_err    <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_cnt     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            ack_err <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        data_q     <= tx_data;
                        parity_q   <= odd_parity(tx_data);
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 2))
                        ps2_dat_oe <= 1'b1;
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        ps2_clk_oe <= 1'b0;
                        edge_cnt   <= '0;
                        state      <= ST_RTS;
                    end
                end
                ST_RTS: begin
                    if (clk_fall) begin
                        ps2_dat_oe <= ~data_q[0];
                        edge_cnt   <= 4'd1;
                        state      <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (clk_fall) begin
                        edge_cnt <= edge_cnt + 4'd1;
                        if (edge_cnt < 4'(DATA_BITS))
                            ps2_dat_oe <= ~data_q[edge_cnt[2:0]];
                        else if (edge_cnt < 4'(STOP_EDGE - 1))
                            ps2_dat_oe <= ~parity_q;
                        else begin
                            ps2_dat_oe <= 1'b0;
                            state      <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (clk_fall) begin
                        ack_bad <= dat_s;
                        state   <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (clk_s && dat_s) begin
                        done    <= 1'b1;
                        ack_err <= ack_bad;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
            if (state == ST_INHIBIT || state == ST_IDLE) begin
                wd_cnt <= '0;
            end else if (clk_fall) begin
                wd_cnt <= '0;
            end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wd_cnt     <= '0;
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                done       <= 1'b1;
                ack_err    <= 1'b0;
                timeout_q  <= 1'b1;
                state      <= ST_IDLE;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
`endif
        end
    end

    // A new byte is only taken once the done pulse has been seen.
    assign tx_ready = (state == ST_IDLE) && !done;
    assign busy     = (state != ST_IDLE);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    // No watchdog in this build; the comparison is constant false.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Honours PS2_HOST_TX_TIMEOUT_EN the same way the design does.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int TB_TIMEOUT = 20000;

    logic       clk_50 = 1'b0;
    logic       areset_n = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ps2_clk_oe, ps2_dat_oe, tx_ready, busy, done, ack_err, timeout;
    wire        ps2_clk = ps2_clk_oe ? 1'b0 : dev_clk;
    wire        ps2_dat = ps2_dat_oe ? 1'b0 : dev_dat;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(5000), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk_50     (clk_50),
        .areset_n   (areset_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout    (timeout)
    );

    always #10 clk_50 = ~clk_50;

    task automatic send_byte(input logic [7:0] d);
        @(posedge clk_50); #1;
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk_50); #1;
        tx_valid = 1'b0;
    endtask

    // Device model: waits for request-to-send, then generates n_falls clocks
    // (1000 ns half-period), sampling data in each high phase before the fall.
    task automatic device_xfer(input int n_falls, input bit do_ack, input int inject_at,
                               output logic [10:0] smp, output bit ok);
        int guard;
        smp = '1;
        ok = 1'b0;
        guard = 0;
        while (!(busy === 1'b1 && ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && guard < 8000) begin
            @(negedge clk_50);
            guard++;
        end
        if (guard >= 8000) return;
        ok = 1'b1;
        for (int i = 0; i < n_falls; i++) begin
            #500;
            smp[i] = ps2_dat;
            if (i == inject_at) begin
                @(posedge clk_50); #1;
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
                n_cmp++;
                if (tx_ready !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL ready_in_xfer: tx_ready=%b required 0", tx_ready);
                end
                @(posedge clk_50); #1;
                tx_valid = 1'b0;
            end
            if (i == 10 && do_ack) dev_dat = 1'b0;
            #500;
            dev_clk = 1'b0;
            #1000;
            dev_clk = 1'b1;
            if (i == 10) dev_dat = 1'b1;
        end
    endtask

    task automatic wait_done(output bit seen, output logic ae, output logic to);
        seen = 1'b0;
        ae = 1'bx;
        to = 1'bx;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk_50);
            if (done === 1'b1) begin
                seen = 1'b1;
                ae = ack_err;
                to = timeout;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #55;
        n_cmp++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout} !== 6'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: clk_oe,dat_oe,busy,done,ack_err,timeout=%b required 000000",
                     {ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout});
        end
        #3 areset_n = 1'b1;
        repeat (3) @(negedge clk_50);
        n_cmp++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_ready: tx_ready=%b busy=%b required 1 0", tx_ready, busy);
        end
    endtask

    task automatic test_send_ed;
        logic [10:0] smp;
        bit ok, seen;
        logic ae, to;
        send_byte(8'hED);
        device_xfer(11, 1'b1, -1, smp, ok);
        n_cmp++;
        if (!ok || smp !== 11'b1_1_11101101_0) begin
            n_bad++;
            $display("[TB] FAIL frame_ed: rts=%0d samples=%b required 1 11111011010", ok, smp);
        end
        wait_done(seen, ae, to);
        n_cmp++;
        if (!seen || ae !== 1'b0 || to !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL done_ed: done=%0d ack_err=%b timeout=%b required 1 0 0", seen, ae, to);
        end
        @(negedge clk_50);
        n_cmp++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL ready_after_done: tx_ready=%b busy=%b required 1 0", tx_ready, busy);
        end
    endtask

    task automatic test_inhibit;
        int n_hi, first;
        logic [10:0] smp;
        bit ok, seen;
        logic ae, to;
        n_hi = 0;
        first = 0;
        send_byte(8'h3C);
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk_50);
            if (ps2_clk_oe !== 1'b1) break;
            n_hi++;
            if (ps2_dat_oe === 1'b1 && first == 0) first = n_hi;
        end
        n_cmp++;
        if (n_hi != 5000) begin
            n_bad++;
            $display("[TB] FAIL inhibit_len: clk_oe high %0d cycles required 5000", n_hi);
        end
        n_cmp++;
        if (first != 5000) begin
            n_bad++;
            $display("[TB] FAIL inhibit_dat: dat_oe rose on cycle %0d required 5000", first);
        end
        n_cmp++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rts_lines: clk_oe=%b dat_oe=%b required 0 1", ps2_clk_oe, ps2_dat_oe);
        end
        device_xfer(11, 1'b1, -1, smp, ok);
        n_cmp++;
        if (!ok || smp !== 11'b1_1_00111100_0) begin
            n_bad++;
            $display("[TB] FAIL frame_3c: rts=%0d samples=%b required 1 11001111000", ok, smp);
        end
        wait_done(seen, ae, to);
        n_cmp++;
        if (!seen || ae !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL done_3c: done=%0d ack_err=%b required 1 0", seen, ae);
        end
    endtask

    task automatic test_no_ack;
        logic [10:0] smp;
        bit ok, seen;
        logic ae, to;
        send_byte(8'h00);
        device_xfer(11, 1'b0, -1, smp, ok);
        n_cmp++;
        if (!ok || smp !== 11'b1_1_00000000_0) begin
            n_bad++;
            $display("[TB] FAIL frame_00: rts=%0d samples=%b required 1 11000000000", ok, smp);
        end
        wait_done(seen, ae, to);
        n_cmp++;
        if (!seen || ae !== 1'b1 || to !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL ack_err: done=%0d ack_err=%b timeout=%b required 1 1 0", seen, ae, to);
        end
    endtask

    task automatic test_ignore_in_xfer;
        logic [10:0] smp;
        bit ok, seen, extra;
        logic ae, to;
        send_byte(8'h5A);
        device_xfer(11, 1'b1, 3, smp, ok);
        n_cmp++;
        if (!ok || smp !== 11'b1_1_01011010_0) begin
            n_bad++;
            $display("[TB] FAIL frame_5a: rts=%0d samples=%b required 1 11010110100", ok, smp);
        end
        wait_done(seen, ae, to);
        n_cmp++;
        if (!seen || ae !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL done_5a: done=%0d ack_err=%b required 1 0", seen, ae);
        end
        extra = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_50);
            if (busy !== 1'b0) extra = 1'b1;
        end
        n_cmp++;
        if (extra) begin
            n_bad++;
            $display("[TB] FAIL ignored_byte: busy seen=1 required 0 (0xFF must not start)");
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] smp;
        bit ok, seen;
        logic ae, to;
        send_byte(8'hA5);
        device_xfer(5, 1'b1, -1, smp, ok);
        n_cmp++;
        if (!ok || smp[4:0] !== 5'b0101_0 || ps2_dat_oe !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL pre_abort: rts=%0d samples=%b dat_oe=%b required 1 01010 1",
                     ok, smp[4:0], ps2_dat_oe);
        end
        areset_n = 1'b0;
        #1;
        n_cmp++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL abort_lines: clk_oe=%b dat_oe=%b busy=%b required 0 0 0",
                     ps2_clk_oe, ps2_dat_oe, busy);
        end
        #50 areset_n = 1'b1;
        repeat (2) @(negedge clk_50);
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL abort_ready: tx_ready=%b required 1", tx_ready);
        end
        send_byte(8'hF4);
        device_xfer(11, 1'b1, -1, smp, ok);
        n_cmp++;
        if (!ok || smp !== 11'b1_0_11110100_0) begin
            n_bad++;
            $display("[TB] FAIL frame_f4: rts=%0d samples=%b required 1 10111101000", ok, smp);
        end
        wait_done(seen, ae, to);
        n_cmp++;
        if (!seen || ae !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL done_f4: done=%0d ack_err=%b required 1 0", seen, ae);
        end
    endtask

    task automatic test_timeout;
        int guard, c;
        bit seen, bad;
        guard = 0;
        send_byte(8'h11);
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1 && busy === 1'b1) && guard < 8000) begin
            @(negedge clk_50);
            guard++;
        end
`ifdef PS2_HOST_TX_TIMEOUT_EN
        c = 0;
        seen = 1'b0;
        bad = 1'b0;
        while (guard < 8000 && c < TB_TIMEOUT + 50) begin
            @(negedge clk_50);
            c++;
            if (done === 1'b1) begin
                seen = 1'b1;
                bad = (timeout !== 1'b1) || (ps2_clk_oe !== 1'b0) || (ps2_dat_oe !== 1'b0);
                break;
            end
        end
        n_cmp++;
        if (!seen || c != TB_TIMEOUT) begin
            n_bad++;
            $display("[TB] FAIL wd_time: done=%0d after %0d cycles required 1 after %0d", seen, c, TB_TIMEOUT);
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("[TB] FAIL wd_outputs: timeout/oe wrong at done, required timeout=1 clk_oe=0 dat_oe=0");
        end
`else
        c = 0;
        seen = 1'b0;
        bad = (guard >= 8000);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_50);
            if (busy !== 1'b1) bad = 1'b1;
            if (done === 1'b1 || timeout !== 1'b0) seen = 1'b1;
            c++;
        end
        n_cmp++;
        if (bad || seen) begin
            n_bad++;
            $display("[TB] FAIL no_wd: busy dropped=%0d done/timeout seen=%0d required 0 0", bad, seen);
        end
        areset_n = 1'b0;
        #45 areset_n = 1'b1;
        repeat (2) @(negedge clk_50);
`endif
    endtask

    initial begin
        test_reset;
        test_send_ed;
        test_inhibit;
        test_no_ack;
        test_ignore_in_xfer;
        test_reset_mid;
        test_timeout;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
